// File: rtl/image_rom_pkg.sv
// image_rom_pkg: shared image ROM geometry and reader FSM states
package image_rom_pkg;
  localparam int IMG_ADDR_W = 12;
  localparam int IMG_DATA_W = 8;
  localparam int IMG_BYTES = 4096;
  localparam int ROM_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/rom_rd_fifo.sv
// rom_rd_fifo: show-ahead synchronous FIFO buffering in-flight ROM reads
// Ports: clk/rst_n (async active-low), i_wr/i_wdata push, i_rd pop,
// o_rdata head entry (valid without a pop), o_full, o_empty, o_count occupancy.
module rom_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wp] <= i_wdata;
        r_wp <= r_wp + AW'(1);
      end
      if (i_rd) r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(i_wr) - CW'(i_rd);
    end
  assign o_rdata = r_mem[r_rp];
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
endmodule

// File: rtl/image_rom_reader.sv
// image_rom_reader: streams a wrapping window of the pipelined image ROM onto a valid/ready bus
// Ports: clk, resetn (async active-low); start/base/len launch a transfer; busy, done status;
// rom_ad/rom_data ROM side; m_data/m_valid/m_ready/m_last output stream.
module image_rom_reader #(
  parameter int ADDR_W = image_rom_pkg::IMG_ADDR_W,
  parameter int DATA_W = image_rom_pkg::IMG_DATA_W,
  parameter int ROM_LATENCY = image_rom_pkg::ROM_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  import image_rom_pkg::*;
  localparam int LW = ADDR_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state;
  logic [ADDR_W-1:0] r_base, r_rom_ad;
  logic [LW-1:0] r_len, r_issue_cnt, r_pop_cnt;
  logic [CW-1:0] r_credit;
  // bit 0 marks the read whose address sits in rom_ad; the top bit lines up with rom_data
  logic [ROM_LATENCY:0] r_vpipe;
  logic r_busy, r_done;
  logic w_idle, w_issue, w_pop, w_last_issue, w_last_pop, w_empty, w_full;
  logic [LW-1:0] w_idx, w_len;
  logic [CW-1:0] w_count;
  logic [DATA_W-1:0] w_head;
  assign w_idle = r_state == IDLE;
  assign w_pop = m_valid && m_ready;
  // the first read is issued on the start edge itself so rom_ad holds base in the next cycle
  assign w_idx = w_idle ? '0 : r_issue_cnt;
  assign w_len = w_idle ? len : r_len;
  // a pop in the same cycle frees one credit, which keeps the stream at one byte per cycle
  assign w_issue = w_idle ? start && len != '0
                          : r_state == FETCH && (r_credit < CW'(FIFO_DEPTH) || w_pop);
  assign w_last_issue = w_idx == w_len - LW'(1);
  assign w_last_pop = w_pop && r_pop_cnt == r_len - LW'(1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_base <= '0;
      r_len <= '0;
      r_rom_ad <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt <= '0;
      r_credit <= '0;
      r_vpipe <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_vpipe <= {r_vpipe[ROM_LATENCY-1:0], w_issue};
      r_credit <= r_credit + CW'(w_issue) - CW'(w_pop);
      if (w_issue) begin
        r_rom_ad <= w_idle ? base : r_base + r_issue_cnt[ADDR_W-1:0];
        r_issue_cnt <= w_idx + LW'(1);
      end
      if (w_pop) r_pop_cnt <= r_pop_cnt + LW'(1);
      case (r_state)
        IDLE: if (start) begin
          r_base <= base;
          r_len <= len;
          r_pop_cnt <= '0;
          r_done <= len == '0;
          r_busy <= len != '0;
          r_state <= len == '0 ? IDLE : w_last_issue ? DRAIN : FETCH;
        end
        FETCH: if (w_issue && w_last_issue) r_state <= DRAIN;
        DRAIN: if (w_last_pop) begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  rom_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_wr    (r_vpipe[ROM_LATENCY]),
    .i_wdata (rom_data),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // credit covers both the ROM pipe and the buffer, so a landing read always finds room
  assert property (@(posedge clk) disable iff (!resetn)
    !(r_vpipe[ROM_LATENCY] && w_full) && w_count <= r_credit);
  assign busy = r_busy;
  assign done = r_done;
  assign rom_ad = r_rom_ad;
  assign m_valid = !w_empty;
  assign m_data = w_head;
  assign m_last = m_valid && r_pop_cnt == r_len - LW'(1);
endmodule
